ahb_slave_decoder: RTL
======================

# ahb_slave_decoder

AHB-Lite address decoder and data-phase sequencer for the two-slave bus. It decodes HADDR into slave selects and registers the data-phase select that drives the response multiplexer's muxSelect. It also contains the default slave: it returns the two-cycle ERROR response for unmapped transfers and a zero-wait OKAY for IDLE/BUSY transfers. It sits between the master's address bus and the Multiplexer, and consumes the multiplexed HREADY as feedback.

## Interface
- ADDR_WIDTH, 32, HADDR width
- SLAVE1_BASE, 32'h0000_0000, slave 1 base address
- SLAVE1_MASK, 32'hFFFF_F000, slave 1 compare mask
- SLAVE2_BASE, 32'h0000_1000, slave 2 base address
- SLAVE2_MASK, 32'hFFFF_F000, slave 2 compare mask

Ports:
- HCLK  in  1  bus clock; all state changes on its rising edge
- HRESET  in  1  synchronous, active-high reset
- HADDR  in  ADDR_WIDTH  address-phase address
- HTRANS  in  2  transfer type: 00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HREADY  in  1  multiplexed HREADY fed back from the bus
- HSEL_1  out  1  combinational slave 1 select
- HSEL_2  out  1  combinational slave 2 select
- muxSelect  out  1  registered data-phase select: 0 = slave 1, 1 = slave 2
- defSel  out  1  registered: default slave owns the current data phase
- defHREADY  out  1  default slave HREADYOUT
- defHRESP  out  1  default slave HRESP (1 = ERROR)

## Operation
- Hit logic: hit1 = (HADDR & SLAVE1_MASK) == SLAVE1_BASE; hit2 = same with SLAVE2 parameters.
- If both hit, slave 1 wins: HSEL_1 = hit1, HSEL_2 = hit2 & ~hit1.
- HSEL_x depend on HADDR only, not on HTRANS.
- Address phase is accepted only on a rising edge with HREADY = 1. With HREADY = 0, muxSelect, defSel and the FSM (except ERR1 -> ERR2) hold.
- Each accepted phase updates the outputs as follows:
  - valid transfer (HTRANS[1] = 1) hitting slave 1: muxSelect <= 0, defSel <= 0, FSM -> IDLE
  - valid transfer hitting slave 2 only: muxSelect <= 1, defSel <= 0, FSM -> IDLE
  - valid transfer hitting neither slave: defSel <= 1, muxSelect holds, FSM -> ERR1
  - IDLE or BUSY transfer (any address): defSel <= 1, muxSelect holds, FSM -> IDLE (OKAY)
- Default-slave FSM states:
  - IDLE: defHREADY = 1, defHRESP = 0
  - ERR1: defHREADY = 0, defHRESP = 1. Always -> ERR2 on the next edge, regardless of HREADY.
  - ERR2: defHREADY = 1, defHRESP = 1. Next state follows the accepted-phase rules above; HREADY is 1 here when defSel = 1.
- Top level routes defHREADY/defHRESP over the Multiplexer outputs when defSel = 1. Read data is don't-care then.

## Timing
- Reset values (HRESET high at an edge): muxSelect = 0, defSel = 1, FSM = IDLE, defHREADY = 1, defHRESP = 0.
- HSEL_x are combinational, zero latency.
- muxSelect and defSel take their new value one cycle after address acceptance, aligned with the data phase.
- An unmapped valid transfer gives exactly 2 data-phase cycles: (HREADY 0, RESP 1) then (HREADY 1, RESP 1).
- A transfer presented in ERR2 is accepted at the end of ERR2 (pipelined). Back-to-back unmapped transfers produce ERR1, ERR2, ERR1, ERR2.
- A slave wait state (HREADY = 0 from slave 1/2) freezes muxSelect; the next address is accepted only on the edge where HREADY = 1.
- Reset asserted mid-ERR1/ERR2 returns to IDLE/OKAY on that edge. No ERR2 is completed.
- IDLE/BUSY always gets a zero-wait OKAY, never ERROR.

## Test plan
- Reset: HRESET = 1 for 2 cycles -> muxSelect = 0, defSel = 1, defHREADY = 1, defHRESP = 0.
- Decode/priority: HADDR = 32'h0000_0010 -> HSEL_1 = 1, HSEL_2 = 0. HADDR = 32'h0000_1FFC -> HSEL_1 = 0, HSEL_2 = 1. With SLAVE2_BASE = 32'h0000_0000 (overlap), HADDR = 32'h0000_0010 -> HSEL_1 = 1, HSEL_2 = 0.
- Pipelined select: NONSEQ 32'h0000_1000 then NONSEQ 32'h0000_0004, HREADY = 1 -> muxSelect = 1 in cycle 1, then 0 in cycle 2, defSel = 0 in both.
- Wait state: NONSEQ to slave 2 accepted, then HREADY = 0 for 3 cycles while HADDR targets slave 1 -> muxSelect stays 1 for all 3 cycles, then 0 one cycle after HREADY returns to 1.
- Unmapped: NONSEQ 32'h0000_8000 -> defSel = 1, then (defHREADY = 0, defHRESP = 1), then (1, 1), then IDLE gives (1, 0). Back-to-back unmapped -> ERR1, ERR2, ERR1, ERR2.
- Reset mid-error: assert HRESET during ERR1 -> next cycle defHREADY = 1, defHRESP = 0, defSel = 1.

Source files
------------

// File: rtl/ahb_slave_decoder.sv
// ---------------------------------------------------------------------------
// ahb_slave_decoder
//
// Purpose:
//   AHB-Lite address decoder and data-phase sequencer for a two-slave bus.
//   It decodes HADDR into slave selects and registers the data-phase select
//   (muxSelect) that steers the response multiplexer.
//
//   It also contains the default slave:
//     - unmapped valid transfers get the two-cycle ERROR response.
//     - IDLE/BUSY transfers get a zero-wait OKAY.
//
// Parameters:
//   ADDR_WIDTH   HADDR width
//   SLAVE1_BASE  slave 1 base address
//   SLAVE1_MASK  slave 1 compare mask
//   SLAVE2_BASE  slave 2 base address
//   SLAVE2_MASK  slave 2 compare mask
//
// Ports:
//   HCLK       in   bus clock; all state changes on its rising edge
//   HRESET     in   synchronous, active-high reset
//   HADDR      in   address-phase address
//   HTRANS     in   transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
//   HREADY     in   multiplexed HREADY fed back from the bus
//   HSEL_1     out  combinational slave 1 select
//   HSEL_2     out  combinational slave 2 select
//   muxSelect  out  registered data-phase select (0 = slave 1, 1 = slave 2)
//   defSel     out  registered; default slave owns the current data phase
//   defHREADY  out  default slave HREADYOUT
//   defHRESP   out  default slave HRESP (1 = ERROR)
// ---------------------------------------------------------------------------
module ahb_slave_decoder #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] SLAVE1_BASE = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] SLAVE1_MASK = 32'hFFFF_F000,
    parameter logic [ADDR_WIDTH-1:0] SLAVE2_BASE = 32'h0000_1000,
    parameter logic [ADDR_WIDTH-1:0] SLAVE2_MASK = 32'hFFFF_F000
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HSEL_1,
    output logic                  HSEL_2,
    output logic                  muxSelect,
    output logic                  defSel,
    output logic                  defHREADY,
    output logic                  defHRESP
);

    // Default slave response states.
    // ERR1 is the first (waited) ERROR cycle; ERR2 is the completing one.
    typedef enum logic [1:0] {
        DEF_IDLE = 2'd0,
        DEF_ERR1 = 2'd1,
        DEF_ERR2 = 2'd2
    } defState_t;

    defState_t stateQ, stateD;
    logic      muxSelQ, muxSelD;
    logic      defSelQ, defSelD;

    logic      hit1;
    logic      hit2;
    logic      validTrans;

    // Address decode is purely combinational on HADDR.
    // HTRANS is deliberately ignored, so the selects are stable as soon as
    // the address is. When the two regions overlap, slave 1 has priority.
    always_comb begin
        hit1       = ((HADDR & SLAVE1_MASK) == SLAVE1_BASE);
        hit2       = ((HADDR & SLAVE2_MASK) == SLAVE2_BASE);
        validTrans = HTRANS[1];
        HSEL_1     = hit1;
        HSEL_2     = hit2 & ~hit1;
    end

    // Next-state logic for the data-phase registers and the default slave.
    //
    // ERR1 always advances to ERR2, because the default slave itself is
    // stalling the bus in ERR1. No new address phase is taken there.
    //
    // In every other state an address phase is accepted only when the
    // multiplexed HREADY is high; otherwise everything holds.
    //
    // muxSelect is left untouched when the default slave takes the phase.
    // The multiplexer output is overridden by defSel in that case anyway.
    always_comb begin
        stateD  = stateQ;
        muxSelD = muxSelQ;
        defSelD = defSelQ;

        if (stateQ == DEF_ERR1) begin
            stateD = DEF_ERR2;
        end else if (HREADY) begin
            if (!validTrans) begin
                defSelD = 1'b1;
                stateD  = DEF_IDLE;
            end else if (hit1) begin
                muxSelD = 1'b0;
                defSelD = 1'b0;
                stateD  = DEF_IDLE;
            end else if (hit2) begin
                muxSelD = 1'b1;
                defSelD = 1'b0;
                stateD  = DEF_IDLE;
            end else begin
                defSelD = 1'b1;
                stateD  = DEF_ERR1;
            end
        end
    end

    // State registers with synchronous reset.
    // Reset leaves the default slave owning the (empty) data phase with an
    // OKAY response. This also aborts an error sequence in progress.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            stateQ  <= DEF_IDLE;
            muxSelQ <= 1'b0;
            defSelQ <= 1'b1;
        end else begin
            stateQ  <= stateD;
            muxSelQ <= muxSelD;
            defSelQ <= defSelD;
        end
    end

    // Default slave response is decoded directly from the state.
    // Only ERR1 stalls the bus. Both error states signal ERROR.
    always_comb begin
        defHREADY = (stateQ != DEF_ERR1);
        defHRESP  = (stateQ != DEF_IDLE);
        muxSelect = muxSelQ;
        defSel    = defSelQ;
    end

endmodule
